// File: rtl/machine_control_unit.sv
// Instruction sequencer: fetches 8-bit instructions, holds PC/IR, and issues memory/ALU strobes.
// Optional macro CU_SINGLE_STEP_EN: every EXEC returns to IDLE, so each instruction needs its own run pulse.
module machine_control_unit #(
    parameter int WIDTH     = 8,
    parameter int OP_BITS   = 3,
    parameter int ADDR_BITS = WIDTH - OP_BITS
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 run,
    input  logic [WIDTH-1:0]     Dbus,
    input  logic [WIDTH-1:0]     Acc,
    output logic [ADDR_BITS-1:0] Abus,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 alu_add,
    output logic                 alu_sub,
    output logic                 alu_write,
    output logic                 alu_read,
    output logic [ADDR_BITS-1:0] pc,
    output logic [WIDTH-1:0]     ir,
    output logic                 halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [OP_BITS-1:0] OP_STP = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_DOD = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_ODE = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_POB = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_LAD = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] OP_SOB = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] OP_SOM = OP_BITS'(6);
    localparam logic [OP_BITS-1:0] OP_SOZ = OP_BITS'(7);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]     ir_q, ir_d;
    logic [OP_BITS-1:0]   opcode;
    logic [ADDR_BITS-1:0] irAddr;
    logic                 jumpTaken;

    assign opcode = ir_q[WIDTH-1 -: OP_BITS];
    assign irAddr = ir_q[ADDR_BITS-1:0];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Branch condition looks at Acc as presented during the EXEC cycle.
    always_comb begin
        jumpTaken = 1'b0;
        case (opcode)
            OP_SOB:  jumpTaken = 1'b1;
            OP_SOM:  jumpTaken = Acc[WIDTH-1];
            OP_SOZ:  jumpTaken = (Acc == '0);
            default: jumpTaken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        Abus      = pc_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        alu_add   = 1'b0;
        alu_sub   = 1'b0;
        alu_write = 1'b0;
        alu_read  = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                mem_rd  = 1'b1;
                ir_d    = Dbus;
                pc_d    = pc_q + ADDR_BITS'(1);
                state_d = EXEC;
            end

            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_STP: begin
                        state_d = IDLE;
                    end
                    OP_DOD: begin
                        Abus      = irAddr;
                        mem_rd    = 1'b1;
                        alu_add   = 1'b1;
                        alu_write = 1'b1;
                    end
                    OP_ODE: begin
                        Abus      = irAddr;
                        mem_rd    = 1'b1;
                        alu_sub   = 1'b1;
                        alu_write = 1'b1;
                    end
                    OP_POB: begin
                        Abus      = irAddr;
                        mem_rd    = 1'b1;
                        alu_write = 1'b1;
                    end
                    OP_LAD: begin
                        Abus     = irAddr;
                        alu_read = 1'b1;
                        mem_wr   = 1'b1;
                    end
                    default: begin
                        // A taken jump replaces the increment made during FETCH.
                        if (jumpTaken) begin
                            pc_d = irAddr;
                        end
                    end
                endcase
`ifdef CU_SINGLE_STEP_EN
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc     = pc_q;
    assign ir     = ir_q;
    assign halted = (state_q == IDLE);

endmodule

// File: tb/tb_machine_control_unit.sv
// Self-checking bench for machine_control_unit: behavioural memory/ALU responders plus a halt-event scoreboard.
module tb_machine_control_unit;

    localparam int WIDTH     = 8;
    localparam int OP_BITS   = 3;
    localparam int ADDR_BITS = 5;
    localparam int DEPTH     = 32;

    logic                 CLK  = 1'b0;
    logic                 RSTn = 1'b0;
    logic                 run  = 1'b0;
    logic [WIDTH-1:0]     Dbus;
    logic [WIDTH-1:0]     Acc;
    logic [ADDR_BITS-1:0] Abus;
    logic                 mem_rd, mem_wr, alu_add, alu_sub, alu_write, alu_read;
    logic [ADDR_BITS-1:0] pc;
    logic [WIDTH-1:0]     ir;
    logic                 halted;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] progImage [DEPTH];
    logic             loadEn = 1'b0;

    int checks     = 0;
    int failures   = 0;
    int cycleCount = 0;
    int startCycle = 0;
    logic haltedPrev = 1'b1;
    bit   ignoreHalts = 1'b0;

    typedef struct {
        string                tag;
        logic [ADDR_BITS-1:0] pc;
        logic [WIDTH-1:0]     acc;
        int                   memAddr;
        logic [WIDTH-1:0]     memData;
        int                   cycles;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    machine_control_unit #(
        .WIDTH(WIDTH),
        .OP_BITS(OP_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .run(run),
        .Dbus(Dbus),
        .Acc(Acc),
        .Abus(Abus),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .alu_add(alu_add),
        .alu_sub(alu_sub),
        .alu_write(alu_write),
        .alu_read(alu_read),
        .pc(pc),
        .ir(ir),
        .halted(halted)
    );

    // Shared bus: whichever responder is strobed drives it.
    assign Dbus = mem_rd ? mem[Abus] : (alu_read ? Acc : '0);

    always @(posedge CLK) begin
        if (loadEn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= progImage[i];
        end else if (mem_wr) begin
            mem[Abus] <= Dbus;
        end
    end

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Acc <= '0;
        end else if (alu_write) begin
            if (alu_add)      Acc <= Acc + Dbus;
            else if (alu_sub) Acc <= Acc - Dbus;
            else              Acc <= Dbus;
        end
    end

    always @(posedge CLK) begin
        cycleCount <= cycleCount + 1;
        if (RSTn && halted && run) startCycle <= cycleCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: each return to IDLE is one completed response to compare against the scoreboard.
    always @(negedge CLK) begin
        if (RSTn && halted && !haltedPrev && !ignoreHalts) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_halt", {27'd0, pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.tag, "_pc"}, {27'd0, pc}, {27'd0, e.pc});
                checkOutput({e.tag, "_acc"}, {24'd0, Acc}, {24'd0, e.acc});
                if (e.memAddr >= 0)
                    checkOutput({e.tag, "_mem"}, {24'd0, mem[e.memAddr]}, {24'd0, e.memData});
                if (e.cycles >= 0)
                    checkOutput({e.tag, "_cycles"}, cycleCount - startCycle, e.cycles);
            end
        end
        haltedPrev <= halted;
    end

    always @(negedge CLK) begin
        if (RSTn) begin
            checkOutput("inv_rd_conflict", {31'd0, mem_rd & alu_read}, 32'd0);
            checkOutput("inv_addsub_conflict", {31'd0, alu_add & alu_sub}, 32'd0);
            checkOutput("inv_wr_without_read", {31'd0, mem_wr & ~alu_read}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t mkExp(string tag, int pcv, int accv, int ma, int md, int cyc);
        exp_t e;
        e.tag     = tag;
        e.pc      = ADDR_BITS'(pcv);
        e.acc     = WIDTH'(accv);
        e.memAddr = ma;
        e.memData = WIDTH'(md);
        e.cycles  = cyc;
        return e;
    endfunction

    task automatic clearImage();
        for (int i = 0; i < DEPTH; i++) progImage[i] = 8'h00;
    endtask

    task automatic doReset();
        @(negedge CLK); #1;
        RSTn   = 1'b0;
        run    = 1'b0;
        loadEn = 1'b1;
        @(negedge CLK); #1;
        loadEn = 1'b0;
        @(negedge CLK); #1;
        RSTn = 1'b1;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge CLK); #1;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout %s pending=%0d required=0", sb[0].tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input exp_t e);
        doReset();
        sb.push_back(e);
        @(negedge CLK);
        run = 1'b1;
        @(negedge CLK);
        run = 1'b0;
        waitDrain(60);
    endtask

    initial begin
        $display("[TB] start");

        // Reset in the middle of a DOD execute cycle
        clearImage();
        progImage[0] = 8'h26;
        progImage[6] = 8'h04;
        doReset();
        @(negedge CLK);
        run = 1'b1;
        @(negedge CLK);
        run = 1'b0;
        checkOutput("fetch_mem_rd", {31'd0, mem_rd}, 32'd1);
        @(negedge CLK);
        checkOutput("dod_strobes", {26'd0, mem_rd, mem_wr, alu_add, alu_sub, alu_write, alu_read}, 32'b101010);
        checkOutput("dod_abus", {27'd0, Abus}, 32'd6);
        checkOutput("dod_ir", {24'd0, ir}, 32'h26);
        #1 RSTn = 1'b0;
        #1;
        checkOutput("rst_strobes", {26'd0, mem_rd, mem_wr, alu_add, alu_sub, alu_write, alu_read}, 32'd0);
        checkOutput("rst_pc", {27'd0, pc}, 32'd0);
        checkOutput("rst_ir", {24'd0, ir}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd1);
        checkOutput("rst_abus", {27'd0, Abus}, 32'd0);
        @(negedge CLK);
        @(negedge CLK); #1;
        RSTn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checkOutput("idle_quiet",
                        {20'd0, halted, pc, mem_rd, mem_wr, alu_add, alu_sub, alu_write, alu_read},
                        32'h800);
        end

`ifdef CU_SINGLE_STEP_EN
        // One run pulse per instruction; run held into FETCH must not matter
        clearImage();
        progImage[0] = 8'h65;
        progImage[1] = 8'h26;
        progImage[2] = 8'h87;
        progImage[3] = 8'h00;
        progImage[5] = 8'h03;
        progImage[6] = 8'h04;
        doReset();
        sb.push_back(mkExp("step_pob", 1, 3, -1, 0, 2));
        sb.push_back(mkExp("step_dod", 2, 7, -1, 0, 2));
        sb.push_back(mkExp("step_lad", 3, 7, 7, 7, 2));
        sb.push_back(mkExp("step_stp", 4, 7, -1, 0, 2));
        for (int s = 0; s < 4; s++) begin
            int before;
            before = sb.size();
            @(negedge CLK);
            run = 1'b1;
            @(negedge CLK);
            @(negedge CLK);
            run = 1'b0;
            for (int i = 0; i < 10 && sb.size() == before; i++) @(negedge CLK);
            #1;
        end
        waitDrain(4);
`else
        // Basic program: POB 5, DOD 6, LAD 7, STP
        clearImage();
        progImage[0] = 8'h65;
        progImage[1] = 8'h26;
        progImage[2] = 8'h87;
        progImage[3] = 8'h00;
        progImage[5] = 8'h03;
        progImage[6] = 8'h04;
        applyStimulus(mkExp("basic", 4, 7, 7, 7, 8));

        // POB 5, ODE 6 -> 0xFF, SOM 31 taken, STP at 31 fetched so pc wraps to 0
        clearImage();
        progImage[0]  = 8'h65;
        progImage[1]  = 8'h46;
        progImage[2]  = 8'hDF;
        progImage[5]  = 8'h03;
        progImage[6]  = 8'h04;
        applyStimulus(mkExp("som_taken_wrap", 0, 8'hFF, -1, 0, 8));

        // SOM not taken with a positive accumulator
        clearImage();
        progImage[0] = 8'h65;
        progImage[1] = 8'hDF;
        progImage[5] = 8'h7F;
        applyStimulus(mkExp("som_not_taken", 3, 8'h7F, -1, 0, 6));

        // SOZ 10 taken on zero, not taken on one
        clearImage();
        progImage[0] = 8'h65;
        progImage[1] = 8'hEA;
        progImage[5] = 8'h00;
        applyStimulus(mkExp("soz_taken", 11, 0, -1, 0, 6));
        progImage[5] = 8'h01;
        applyStimulus(mkExp("soz_not_taken", 3, 1, -1, 0, 6));

        // SOB 0 forever: pc alternates 0/1 and never halts
        clearImage();
        progImage[0] = 8'hA0;
        doReset();
        @(negedge CLK);
        run = 1'b1;
        @(negedge CLK);
        run = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checkOutput("sob_loop_pc", {27'd0, pc}, (k % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("sob_loop_running", {31'd0, halted}, 32'd0);
            @(negedge CLK);
        end
`endif

        // Random program with run held high; only the bus invariants are judged
        ignoreHalts = 1'b1;
        for (int i = 0; i < DEPTH; i++) progImage[i] = WIDTH'($urandom_range(0, 255));
        doReset();
        run = 1'b1;
        repeat (300) @(negedge CLK);
        run = 1'b0;
        doReset();
        ignoreHalts = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
